// File: rtl/modn_pkg.sv
// modn_pkg: direction codes and the shared modulo next-value helper for mod-N counters
package modn_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Returns {wrap, next}; a step of MODULUS or more is reduced once by MODULUS.
    function automatic logic [32:0] modn_next(
        input logic [31:0] count,
        input logic [31:0] step,
        input logic        dir,
        input logic [31:0] modulus
    );
        logic [31:0] st;
        st = (step >= modulus) ? step - modulus : step;
        if (dir == DIR_UP)
            return (count + st >= modulus) ? {1'b1, count + st - modulus} : {1'b0, count + st};
        return (count >= st) ? {1'b0, count - st} : {1'b1, count + modulus - st};
    endfunction

endpackage

// File: rtl/modn_updown_counter.sv
// modn_updown_counter: modulo-N up/down counter with step, clear, checked load and cascade outputs
module modn_updown_counter
    import modn_pkg::*;
#(
    parameter int MODULUS = 12,
    parameter int WIDTH   = $clog2(MODULUS),
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             tc_out,
    output logic             wrap,
    output logic             load_err
);

    logic [32:0]      nx;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             err_d;
    logic             bad_load;
    logic             advance;
    logic             unused_nx;

    assign nx        = modn_next(32'(count), 32'(step), mode, 32'(MODULUS));
    assign unused_nx = ^nx[31:WIDTH];
    assign bad_load  = 32'(data_in) >= 32'(MODULUS);
    assign advance   = en && (step != '0);

    // clr outranks load, which outranks counting; out-of-range loads saturate
    always_comb begin
        count_d = clr ? '0 : load ? (bad_load ? WIDTH'(MODULUS - 1) : data_in) : advance ? nx[WIDTH-1:0] : count;
        wrap_d  = !clr && !load && advance && nx[32];
        err_d   = !clr && load && bad_load;
    end

    assign tc_out = en && !clr && !load && (mode ? (count == WIDTH'(MODULUS - 1)) : (count == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= WIDTH'(RST_VAL);
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_d;
            wrap     <= wrap_d;
            load_err <= err_d;
        end
    end

endmodule
